program_loader: RTL
===================

# program_loader

Byte-stream program loader that drives the CPU's instruction-RAM write port and run control. It accepts a length header and little-endian instruction words over a valid/ready byte interface, writes each word to consecutive RAM addresses from 0, then asserts `PC_Enable` so the CPU starts executing. It sits between the host/serial front end and the CPU's `RAM_Write_*` and `PC_Enable` inputs, and replaces bench-driven program loading.

## Interface
- `ADDR_W`, default 3: RAM address width; the maximum program length is 2^ADDR_W words.
- `DATA_W`, default 11: instruction width, 9..16; bits above DATA_W-1 in a word must be zero.

- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `RAM_Write_Data`, output, DATA_W: instruction word to the CPU RAM.
- `RAM_Write_Address`, output, ADDR_W: RAM write address.
- `RAM_Write_Enable`, output, 1: one-cycle write strobe.
- `PC_Enable`, output, 1: CPU run enable.
- `done`, output, 1: program loaded and CPU released.
- `error`, output, 1: stream rejected (sticky).

## Operation
- Transfer rule: a byte is accepted on a rising edge where `in_valid && in_ready`.
- State HDR:
  - `in_ready=1`.
  - Accepted byte is N.
  - If 1 ≤ N ≤ 2^ADDR_W, go to LO with `addr=0` and `remaining=N`.
  - Otherwise go to ERR. This includes N=0.
- State LO: `in_ready=1`. Capture `lo`, go to HI.
- State HI:
  - `in_ready=1`. Capture `hi`.
  - If `hi[7:DATA_W-8] != 0`, go to ERR.
  - Otherwise go to WR.
- State WR:
  - `in_ready=0`, `RAM_Write_Enable=1`, `RAM_Write_Data={hi[DATA_W-9:0],lo}`, `RAM_Write_Address=addr`.
  - Next cycle: `addr++` and `remaining--`.
  - If `remaining` was 1, go to RUN (or CHK when the checksum is compiled in). Otherwise go to LO.
- State RUN:
  - `in_ready=0`, `PC_Enable=1`, `done=1`.
  - Held until reset. Bytes offered here are not accepted.
- State ERR:
  - `in_ready=0`, `error=1`, `PC_Enable=0`.
  - Held until reset.
  - Words already written stay in RAM. The loader does not undo them.
- `RAM_Write_Data` and `RAM_Write_Address` hold their last values outside WR. Only `RAM_Write_Enable` qualifies them.
- `addr` never wraps: the header bound guarantees the last write is at address N-1 ≤ 2^ADDR_W-1.

## Timing
- Reset values:
  - State HDR, `in_ready=1`.
  - `RAM_Write_Enable=0`, `RAM_Write_Data=0`, `RAM_Write_Address=0`.
  - `PC_Enable=0`, `done=0`, `error=0`.
- All outputs are registered or decoded from registered state. `in_ready` has no combinational dependence on `in_valid`.
- Per-word throughput is 3 cycles minimum: LO, HI, WR.
- `RAM_Write_Enable` is high exactly one cycle, the cycle after the HI byte is accepted.
- `PC_Enable` and `done` rise the cycle after the last WR (no checksum), or the cycle after the checksum byte is accepted.
- `in_valid` low stalls in the current state indefinitely, with no timeout.
- Reset mid-load: next cycle is HDR with all outputs at reset values. The next header byte restarts at address 0.
- Reset while in RUN drops `PC_Enable` on the next edge.

## Configuration
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last WR, state CHK with `in_ready=1`.
  - The accepted byte must equal the XOR of the header and every data byte.
  - Match: go to RUN.
  - Mismatch: go to ERR, and `PC_Enable` never asserts.
- Undefined: no CHK state and no checksum byte; the transition goes WR → RUN directly.

## Test plan
- Load N=1, bytes 0x01, 0x84, 0x01 (word 0x184, "ADD R0,INR") → one write of 0x184 at address 0, `PC_Enable=1` and `done=1` the cycle after the write. With CHK, append 0x84.
- Load N=7 with the 7-word demo program, with `in_valid` low for random gaps → writes at addresses 0..6 in order with exact data, one `RAM_Write_Enable` per word, `PC_Enable` only after address 6.
- Header 0x00, and separately header 0x09 → `error=1`, no `RAM_Write_Enable` ever, `in_ready=0`.
- N=2 with the second word's high byte 0x08 → one write at address 0, then `error=1`, `PC_Enable` stays 0.
- Assert `reset` for one cycle after the first word's write, then send a full N=2 load → writes restart at address 0, correct completion.
- With `PROGRAM_LOADER_CHECKSUM_EN` and N=1, bytes 0x01, 0x84, 0x01, checksum 0x00 (correct value 0x84) → `error=1`, `PC_Enable=0`.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: byte-stream loader for the CPU instruction RAM.
//
// Stream format: one length byte N (1..2^ADDR_W), then N little-endian words
// sent as a low byte followed by a high byte. Each word is written to
// consecutive RAM addresses starting at 0. After the last word the CPU is
// released through PC_Enable. A bad header or a high byte with bits set above
// DATA_W-1 parks the loader in a sticky error state until reset.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte is expected after the last word.
//   It must equal the XOR of the header and every data byte, otherwise the
//   loader errors out instead of releasing the CPU.
module program_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] RAM_Write_Data,
    output logic [ADDR_W-1:0] RAM_Write_Address,
    output logic              RAM_Write_Enable,
    output logic              PC_Enable,
    output logic              done,
    output logic              error
);

    // remaining has to hold the full word count 2^ADDR_W, so it gets one extra bit
    localparam int REM_W     = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;

    // Bits of the high byte that would fall above the instruction width
    localparam logic [7:0] HI_MASK = 8'hFF << (DATA_W - 8);

    typedef enum logic [2:0] {
        S_HDR,
        S_LO,
        S_HI,
        S_WR,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REM_W-1:0]    remaining_q, remaining_d;
    logic [7:0]          lo_q, lo_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic                accept;
    logic                hdr_ok;
    logic                hi_ok;
    logic                last_word;
    logic [DATA_W-1:0]   word;

    // Decode of the byte currently offered, used by the next-state logic
    always_comb begin
        hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= 32'(MAX_WORDS));
        hi_ok     = (in_data & HI_MASK) == 8'd0;
        word      = {in_data[DATA_W-9:0], lo_q};
        last_word = (remaining_q == REM_W'(1));
        accept    = in_valid && in_ready;
    end

    // Output decode from the registered state; write port holds between strobes
    always_comb begin
        in_ready          = (state_q == S_HDR) || (state_q == S_LO) ||
                            (state_q == S_HI)  || (state_q == S_CHK);
        RAM_Write_Enable  = (state_q == S_WR);
        RAM_Write_Data    = wdata_q;
        RAM_Write_Address = waddr_q;
        PC_Enable         = (state_q == S_RUN);
        done              = (state_q == S_RUN);
        error             = (state_q == S_ERR);
    end

    // Next-state logic: header check, byte capture, write sequencing
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        lo_d        = lo_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        case (state_q)
            S_HDR: begin
                if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d = in_data;
`endif
                    if (hdr_ok) begin
                        addr_d      = '0;
                        remaining_d = REM_W'(in_data);
                        state_d     = S_LO;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_LO: begin
                if (accept) begin
                    lo_d    = in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ in_data;
`endif
                    state_d = S_HI;
                end
            end

            S_HI: begin
                if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if (hi_ok) begin
                        // Latch the word and its address so they are stable during WR
                        wdata_d = word;
                        waddr_d = addr_q;
                        state_d = S_WR;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_WR: begin
                remaining_d = remaining_q - REM_W'(1);
                if (last_word) begin
                    // Address is left on the final word rather than stepping past the RAM
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_LO;
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`endif

            S_RUN: begin
                state_d = S_RUN;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            addr_q      <= '0;
            remaining_q <= '0;
            lo_q        <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            lo_q        <= lo_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR of header and data bytes for the trailing checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule
